pcie_rx_tlp_router: RTL and testbench
=====================================

# pcie_rx_tlp_router

Receive-side TLP classifier and router that sits directly downstream of `pcie_endpoint`. It consumes the endpoint's 256-bit `m_axis_rx_*` AXI-Stream, decodes the header of each TLP, and steers whole packets to a request stream or a completion stream. Poisoned, error-forwarded, message and unsupported TLPs are discarded, with status pulses for the endpoint's `cfg_err_*` logic. Straddling is not supported: every TLP starts at DW0 of the beat following a `tlast` beat.

## Interface
Parameters:
- `DATA_W`, default 256: stream data width in bits.
- `KEEP_W`, default 32: `DATA_W/8`.
- `USER_W`, default 22: `tuser` width, matching the endpoint's `m_axis_rx_tuser`.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- Clock and reset: one clock, `user_clk`. Reset is synchronous and active-high, `user_reset`, the same signal the endpoint outputs.
- `user_clk` in 1: clock.
- `user_reset` in 1: synchronous active-high reset.
- `s_axis_rx_tdata` in DATA_W: TLP data; DW0 is in [31:0].
- `s_axis_rx_tkeep` in KEEP_W: byte enables.
- `s_axis_rx_tlast` in 1: last beat of a TLP.
- `s_axis_rx_tvalid` in 1: input beat valid.
- `s_axis_rx_tready` out 1: input beat accepted.
- `s_axis_rx_tuser` in USER_W: bit[1] is err_fwd; bits[9:2] are bar_hit.
- `m_axis_req_tdata/tkeep/tlast/tvalid/tuser` out: request stream (MRd, MRdLk, MWr, IORd, IOWr, CfgRd/Wr0/1).
- `m_axis_req_tready` in 1: request stream ready.
- `m_axis_cpl_tdata/tkeep/tlast/tvalid/tuser` out: completion stream (Cpl, CplD, CplLk, CplDLk).
- `m_axis_cpl_tready` in 1: completion stream ready.
- `ur_pulse` out 1: one-cycle pulse when an unsupported-type TLP header is accepted.
- `poison_pulse` out 1: one-cycle pulse when a header with EP=1 is accepted.
- `drop_cnt` out CNT_W: count of dropped TLPs (all reasons).
- `ur_cnt` out CNT_W: count of unsupported-type TLPs.

## Operation
Header decode, combinational on the first beat:
- fmt = [31:29], type = [28:24], EP = [14].
- type 0000x, 00010, 0010x → REQ.
- type 0101x → CPL.
- type 10xxx (message) → DROP, with no UR.
- Any other type → DROP and assert `ur_pulse`.
- EP=1 or tuser[1]=1 overrides the type class → DROP. EP=1 also asserts `poison_pulse`. These overrides do not produce UR.

State machine:
- States: SOF (the next accepted beat is a header), REQ, CPL, DROP.
- SOF, header accepted with tlast=1 → stay in SOF.
- SOF, header accepted with tlast=0 → go to the state given by the header class.
- REQ/CPL/DROP: on an accepted beat with tlast=1 → SOF.

Output stages:
- Each output stream has one register stage.
- A stage can load when its valid is 0 or its tready is 1.
- The whole beat (data/keep/last/user) is copied unmodified.

Input ready:
- In SOF, tready = loadability of the target stage, or 1 if the class is DROP.
- In REQ or CPL, tready = loadability of that stage.
- In DROP, tready = 1 (dropped beats are consumed at full rate).

Counters:
- A counter increments once per dropped TLP, at header acceptance.
- Counters saturate at all-ones and do not wrap.

## Timing
- Latency is 1 cycle from an input handshake to output tvalid.
- Throughput is 1 beat per cycle when the target output is continuously ready.
- An output tvalid, once asserted, holds with stable payload until its tready is sampled high.
- The two output streams are independent. A stall on one blocks the input only while the current TLP targets that stream.
- `ur_pulse` and `poison_pulse` assert in the cycle after the header handshake, for exactly 1 cycle.
- Reset values:
  - state = SOF.
  - All output tvalid = 0; tdata/tkeep/tuser/tlast = 0.
  - `s_axis_rx_tready` = 0 while `user_reset` is high.
  - Pulses = 0; counters = 0.
- Reset mid-packet abandons the packet in both stages. The upstream endpoint is reset by the same signal, so no partial packet follows.
- Single-beat TLP (header with tlast=1): routed or dropped entirely in the SOF state.

## Configuration
- Macro: `PCIE_RX_ROUTER_STATS_EN`.
- Defined: `drop_cnt` and `ur_cnt` are implemented as described.
- Undefined: both counters are tied to 0 and their logic is removed.
- `ur_pulse` and `poison_pulse` are present in both configurations.

## Test plan
- 3-beat MWr (DW0=0x4000_0010, bar_hit=0x01), both readys high → identical 3 beats on req one cycle later; cpl idle; drop_cnt stays 0.
- 1-beat CplD (DW0=0x4A00_0001, tlast=1) while `m_axis_req_tready`=0 → emerges on cpl with no stall; req valid holds unchanged.
- MRd with EP=1 (DW0=0x0000_4001), 2 beats → no output beats; `poison_pulse` for 1 cycle; drop_cnt=1; input tready=1 throughout.
- Header type 0x1F (DW0=0x1F00_0000) → dropped; `ur_pulse` 1 cycle; ur_cnt=1. Msg header (DW0=0x3000_0000) → dropped; ur_cnt unchanged.
- Random backpressure on req during a 4-beat MWr → output order and payload intact, no beat duplicated or lost. Assert `user_reset` on beat 2 → all valids 0 next cycle, state SOF.
- With `PCIE_RX_ROUTER_STATS_EN` and CNT_W=4, drop 20 TLPs → drop_cnt saturates at 0xF. Without the macro → drop_cnt reads 0.

Source files
------------

// File: rtl/pcie_rx_tlp_router_if.sv
// ----------------------------------------------------------------------------
// pcie_rx_tlp_router_if
// AXI-Stream bundle used on every stream port of pcie_rx_tlp_router.
//
// Signals:
//   tdata  [DATA_W] : beat data, DW0 in [31:0]
//   tkeep  [KEEP_W] : byte enables
//   tlast           : last beat of a TLP
//   tuser  [USER_W] : sideband (bit[1] err_fwd, bits[9:2] bar_hit)
//   tvalid          : beat valid (source -> sink)
//   tready          : beat accepted (sink -> source)
// Modports:
//   master : drives the payload and tvalid, samples tready
//   slave  : samples the payload and tvalid, drives tready
// ----------------------------------------------------------------------------
interface pcie_rx_tlp_router_if #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int USER_W = 22
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input  tready);
  modport slave  (input  tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pcie_rx_tlp_router.sv
// ----------------------------------------------------------------------------
// pcie_rx_tlp_router
// Receive-side TLP classifier. Decodes the header beat of each TLP arriving
// from the endpoint and steers the whole packet to the request stream, the
// completion stream, or discards it. Straddled TLPs are not supported: a
// header always sits at DW0 of the beat after a tlast beat.
//
// Ports:
//   user_clk     in  : clock
//   user_reset   in  : synchronous active-high reset
//   s_axis_rx    slave  : input TLP stream from the endpoint
//   m_axis_req   master : MRd/MRdLk/MWr/IORd/IOWr/CfgRd/Wr0/1
//   m_axis_cpl   master : Cpl/CplD/CplLk/CplDLk
//   ur_pulse     out : 1-cycle pulse, unsupported-type header accepted
//   poison_pulse out : 1-cycle pulse, header with EP=1 accepted
//   drop_cnt     out : saturating count of dropped TLPs
//   ur_cnt       out : saturating count of unsupported-type TLPs
//
// Build option: define PCIE_RX_ROUTER_STATS_EN to implement drop_cnt/ur_cnt;
// when undefined both read as zero and their logic is removed.
// ----------------------------------------------------------------------------
module pcie_rx_tlp_router #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int USER_W = 22,
  parameter int CNT_W  = 16
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  pcie_rx_tlp_router_if.slave  s_axis_rx,
  pcie_rx_tlp_router_if.master m_axis_req,
  pcie_rx_tlp_router_if.master m_axis_cpl,
  output logic                 ur_pulse,
  output logic                 poison_pulse,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     ur_cnt
);

  typedef enum logic [1:0] {ST_SOF, ST_REQ, ST_CPL, ST_DROP} state_t;
  typedef enum logic [1:0] {CLS_REQ, CLS_CPL, CLS_DROP} cls_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  state_t r_state;
  state_t w_state_nxt;
  cls_t   w_hdr_class;
  cls_t   w_target;

  beat_t  w_in_beat;
  beat_t  r_req_beat;
  beat_t  r_cpl_beat;
  logic   r_req_tvalid;
  logic   r_cpl_tvalid;

  logic   r_ur_pulse;
  logic   r_poison_pulse;

  logic [4:0] w_type;
  logic       w_ep;
  logic       w_err_fwd;
  logic       w_type_req;
  logic       w_type_cpl;
  logic       w_type_msg;
  logic       w_override;
  logic       w_hdr_ur;

  logic       w_req_ok;
  logic       w_cpl_ok;
  logic       w_s_tready;
  logic       w_fire;
  logic       w_hdr_fire;
  logic       w_req_load;
  logic       w_cpl_load;

  // --------------------------------------------------------------------------
  // Header decode (only meaningful on the SOF beat). fmt [31:29] is not needed
  // to classify: the type field alone separates the supported classes.
  // --------------------------------------------------------------------------
  assign w_type    = s_axis_rx.tdata[28:24];
  assign w_ep      = s_axis_rx.tdata[14];
  assign w_err_fwd = s_axis_rx.tuser[1];

  assign w_type_req = (w_type[4:1] == 4'b0000) ||   // MRd, MRdLk
                      (w_type      == 5'b00010) ||  // IORd/IOWr
                      (w_type[4:1] == 4'b0010);     // CfgRd/Wr0/1
  assign w_type_cpl = (w_type[4:1] == 4'b0101);     // Cpl/CplD/CplLk/CplDLk
  assign w_type_msg = (w_type[4:3] == 2'b10);       // messages: silent drop

  // Poison or error-forward wins over the type class and suppresses UR.
  assign w_override = w_ep || w_err_fwd;
  assign w_hdr_ur   = !w_override && !w_type_req && !w_type_cpl && !w_type_msg;

  always_comb begin
    // NOTE: every variable gets a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_hdr_class = CLS_DROP;
    if (!w_override) begin
      if (w_type_req)      w_hdr_class = CLS_REQ;
      else if (w_type_cpl) w_hdr_class = CLS_CPL;
    end
  end

  // --------------------------------------------------------------------------
  // Output-stage loadability and input handshake
  // --------------------------------------------------------------------------
  assign w_req_ok = !r_req_tvalid || m_axis_req.tready;
  assign w_cpl_ok = !r_cpl_tvalid || m_axis_cpl.tready;

  assign w_fire     = s_axis_rx.tvalid && w_s_tready;
  assign w_hdr_fire = w_fire && (r_state == ST_SOF);
  assign w_req_load = w_fire && (w_target == CLS_REQ);
  assign w_cpl_load = w_fire && (w_target == CLS_CPL);

  assign w_in_beat = '{data: s_axis_rx.tdata, keep: s_axis_rx.tkeep,
                       last: s_axis_rx.tlast, user: s_axis_rx.tuser};

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (user_reset) r_state <= ST_SOF;
    else            r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SOF: begin
        if (w_fire && !s_axis_rx.tlast) begin
          case (w_hdr_class)
            CLS_REQ: w_state_nxt = ST_REQ;
            CLS_CPL: w_state_nxt = ST_CPL;
            default: w_state_nxt = ST_DROP;
          endcase
        end
      end
      default: begin
        if (w_fire && s_axis_rx.tlast) w_state_nxt = ST_SOF;
      end
    endcase
  end

  // FSM: outputs (beat target and input ready)
  always_comb begin
    w_target = CLS_DROP;
    case (r_state)
      ST_SOF:  w_target = w_hdr_class;
      ST_REQ:  w_target = CLS_REQ;
      ST_CPL:  w_target = CLS_CPL;
      default: w_target = CLS_DROP;
    endcase

    case (w_target)
      CLS_REQ: w_s_tready = w_req_ok;
      CLS_CPL: w_s_tready = w_cpl_ok;
      default: w_s_tready = 1'b1;   // dropped beats are consumed at full rate
    endcase
    if (user_reset) w_s_tready = 1'b0;
  end

  assign s_axis_rx.tready = w_s_tready;

  // --------------------------------------------------------------------------
  // Output register stages. When a stage may load, its valid follows the load
  // request; otherwise valid and payload hold until tready.
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_req_tvalid <= 1'b0;
      // NOTE: payload registers are reset too, so downstream sees zeros rather
      // than stale data after reset; this costs a reset net on wide flops.
      r_req_beat   <= '0;
    end else if (w_req_ok) begin
      r_req_tvalid <= w_req_load;
      if (w_req_load) r_req_beat <= w_in_beat;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_cpl_tvalid <= 1'b0;
      r_cpl_beat   <= '0;
    end else if (w_cpl_ok) begin
      r_cpl_tvalid <= w_cpl_load;
      if (w_cpl_load) r_cpl_beat <= w_in_beat;
    end
  end

  assign m_axis_req.tvalid = r_req_tvalid;
  assign m_axis_req.tdata  = r_req_beat.data;
  assign m_axis_req.tkeep  = r_req_beat.keep;
  assign m_axis_req.tlast  = r_req_beat.last;
  assign m_axis_req.tuser  = r_req_beat.user;

  assign m_axis_cpl.tvalid = r_cpl_tvalid;
  assign m_axis_cpl.tdata  = r_cpl_beat.data;
  assign m_axis_cpl.tkeep  = r_cpl_beat.keep;
  assign m_axis_cpl.tlast  = r_cpl_beat.last;
  assign m_axis_cpl.tuser  = r_cpl_beat.user;

  // --------------------------------------------------------------------------
  // Status pulses: registered, so they appear the cycle after the header
  // handshake and last exactly one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_ur_pulse     <= 1'b0;
      r_poison_pulse <= 1'b0;
    end else begin
      r_ur_pulse     <= w_hdr_fire && w_hdr_ur;
      r_poison_pulse <= w_hdr_fire && w_ep;
    end
  end

  assign ur_pulse     = r_ur_pulse;
  assign poison_pulse = r_poison_pulse;

  // --------------------------------------------------------------------------
  // Statistics counters (saturating, bumped once per TLP at header accept)
  // --------------------------------------------------------------------------
`ifdef PCIE_RX_ROUTER_STATS_EN
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_ur_cnt;
  logic             w_hdr_drop;

  assign w_hdr_drop = w_hdr_fire && (w_hdr_class == CLS_DROP);

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      r_drop_cnt <= '0;
      r_ur_cnt   <= '0;
    end else begin
      if (w_hdr_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      if (w_hdr_fire && w_hdr_ur && (r_ur_cnt != '1))
        r_ur_cnt <= r_ur_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign ur_cnt   = r_ur_cnt;
`else
  assign drop_cnt = '0;
  assign ur_cnt   = '0;
`endif

endmodule

// File: tb/tb_pcie_rx_tlp_router.sv
// ----------------------------------------------------------------------------
// tb_pcie_rx_tlp_router
// Directed bench for pcie_rx_tlp_router. Accepted input beats that should be
// routed are pushed to a per-stream expected queue; a monitor pops and
// compares each output handshake. Counters use CNT_W=4 so saturation is
// reachable; expectations follow PCIE_RX_ROUTER_STATS_EN.
// ----------------------------------------------------------------------------
module tb_pcie_rx_tlp_router;

  localparam int DATA_W = 256;
  localparam int KEEP_W = 32;
  localparam int USER_W = 22;
  localparam int CNT_W  = 4;

`ifdef PCIE_RX_ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [USER_W-1:0] USR_BAR1 = 22'h000004;  // bar_hit = 0x01
  localparam logic [USER_W-1:0] USR_EFWD = 22'h000006;  // bar_hit 0x01, err_fwd

  typedef enum int {R_DROP, R_REQ, R_CPL} route_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic user_clk = 1'b0;
  logic user_reset;
  logic ur_pulse, poison_pulse;
  logic [CNT_W-1:0] drop_cnt, ur_cnt;

  pcie_rx_tlp_router_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) s_if ();
  pcie_rx_tlp_router_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) req_if ();
  pcie_rx_tlp_router_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) cpl_if ();

  pcie_rx_tlp_router #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
    .user_clk     (user_clk),
    .user_reset   (user_reset),
    .s_axis_rx    (s_if),
    .m_axis_req   (req_if),
    .m_axis_cpl   (cpl_if),
    .ur_pulse     (ur_pulse),
    .poison_pulse (poison_pulse),
    .drop_cnt     (drop_cnt),
    .ur_cnt       (ur_cnt)
  );

  always #5 user_clk = ~user_clk;

  // Ready generation: req can run random backpressure, cpl is directed.
  bit   bp_en = 1'b0;
  bit   bp_rand = 1'b1;
  logic req_ready_force;
  logic cpl_ready;
  assign req_if.tready = bp_en ? bp_rand : req_ready_force;
  assign cpl_if.tready = cpl_ready;

  always @(posedge user_clk) begin
    #1 bp_rand = 1'($urandom_range(0, 1));
  end

  int    n_vec = 0;
  int    n_err = 0;
  beat_t req_q[$];
  beat_t cpl_q[$];
  logic [CNT_W-1:0] exp_drop = '0;
  logic [CNT_W-1:0] exp_ur   = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] dw0);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    d[31:0] = dw0;
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (!STATS) return '0;
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Output monitor: sampled on the falling edge, where valid/ready are stable
  // for the handshake at the next rising edge.
  task automatic compare_out(input string tag, input beat_t obs, ref beat_t q[$]);
    beat_t e;
    n_vec++;
    assert (q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_unexpected: observed beat %0h expected none", tag, obs.data[63:0]);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_beat"}, DATA_W'(obs), DATA_W'(e));
    end
  endtask

  always @(negedge user_clk) begin
    if (req_if.tvalid && req_if.tready)
      compare_out("req", '{data: req_if.tdata, keep: req_if.tkeep,
                           last: req_if.tlast, user: req_if.tuser}, req_q);
    if (cpl_if.tvalid && cpl_if.tready)
      compare_out("cpl", '{data: cpl_if.tdata, keep: cpl_if.tkeep,
                           last: cpl_if.tlast, user: cpl_if.tuser}, cpl_q);
  end

  // Drive one beat and hold it until accepted; returns just after the
  // accepting edge with the number of stalled cycles.
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                           input logic l, input logic [USER_W-1:0] u,
                           input route_t r, output int waits);
    bit got;
    beat_t b;
    b = '{data: d, keep: k, last: l, user: u};
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = u;
    s_if.tvalid = 1'b1;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 200) begin
      @(negedge user_clk);
      if (s_if.tready) got = 1'b1;
      else waits++;
    end
    n_vec++;
    assert (got) else begin
      n_err++;
      $error("FAIL send_timeout: observed no tready after %0d cycles expected accept", waits);
    end
    if (got) begin
      if (r == R_REQ) req_q.push_back(b);
      if (r == R_CPL) cpl_q.push_back(b);
    end
    @(posedge user_clk); #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) begin @(posedge user_clk); #1; end
  endtask

  initial begin
    int w;
    logic [DATA_W-1:0] d0, held;

    s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    s_if.tvalid = 1'b0;
    req_ready_force = 1'b1;
    cpl_ready = 1'b1;
    user_reset = 1'b1;

    // ---- Reset state ------------------------------------------------------
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_req_valid", req_if.tvalid, 0);
    check("rst_cpl_valid", cpl_if.tvalid, 0);
    check("rst_req_data",  req_if.tdata, 0);
    check("rst_cpl_last",  cpl_if.tlast, 0);
    check("rst_tready",    s_if.tready, 0);
    check("rst_pulses",    {ur_pulse, poison_pulse}, 0);
    check("rst_cnts",      {drop_cnt, ur_cnt}, 0);
    user_reset = 1'b0;
    idle(1);

    // ---- 3-beat MWr, both readys high ------------------------------------
    d0 = mk_data(32'h4000_0010);
    send_beat(d0, '1, 1'b0, USR_BAR1, R_REQ, w);
    check("mwr_lat_valid", req_if.tvalid, 1);
    check("mwr_lat_data",  req_if.tdata, d0);
    check("mwr_cpl_idle",  cpl_if.tvalid, 0);
    send_beat(mk_data($urandom), '1, 1'b0, USR_BAR1, R_REQ, w);
    send_beat(mk_data($urandom), 32'h0000_00FF, 1'b1, USR_BAR1, R_REQ, w);
    check("mwr_full_rate", w, 0);
    idle(3);
    check("mwr_drained", req_q.size(), 0);
    check("mwr_drop_cnt", drop_cnt, exp_drop);

    // ---- CplD passes while req is stalled --------------------------------
    req_ready_force = 1'b0;
    held = mk_data(32'h4000_0010);
    send_beat(held, '1, 1'b1, USR_BAR1, R_REQ, w);
    check("stall_req_valid", req_if.tvalid, 1);
    d0 = mk_data(32'h4A00_0001);
    send_beat(d0, 32'h0000_0FFF, 1'b1, '0, R_CPL, w);
    check("cpl_no_stall",   w, 0);
    check("cpl_lat_valid",  cpl_if.tvalid, 1);
    check("cpl_lat_data",   cpl_if.tdata, d0);
    check("req_hold_valid", req_if.tvalid, 1);
    check("req_hold_data",  req_if.tdata, held);
    idle(2);
    check("req_hold_data2", req_if.tdata, held);
    check("cpl_drained",    cpl_q.size(), 0);
    req_ready_force = 1'b1;
    idle(2);
    check("req_released",   req_q.size(), 0);

    // ---- Poisoned MRd, 2 beats --------------------------------------------
    send_beat(mk_data(32'h0000_4001), '1, 1'b0, USR_BAR1, R_DROP, w);
    exp_drop = sat_inc(exp_drop);
    check("ep_hdr_ready",  w, 0);
    check("ep_poison",     poison_pulse, 1);
    check("ep_no_ur",      ur_pulse, 0);
    check("ep_drop_cnt",   drop_cnt, exp_drop);
    send_beat(mk_data($urandom), '1, 1'b1, USR_BAR1, R_DROP, w);
    check("ep_data_ready", w, 0);
    check("ep_poison_1cy", poison_pulse, 0);
    idle(2);
    check("ep_no_out", {req_if.tvalid, cpl_if.tvalid}, 0);

    // ---- Error-forwarded MWr: dropped, no pulses --------------------------
    send_beat(mk_data(32'h4000_0010), '1, 1'b1, USR_EFWD, R_DROP, w);
    exp_drop = sat_inc(exp_drop);
    check("efwd_pulses",   {ur_pulse, poison_pulse}, 0);
    check("efwd_drop_cnt", drop_cnt, exp_drop);

    // ---- Unsupported type, then message -----------------------------------
    send_beat(mk_data(32'h1F00_0000), '1, 1'b1, '0, R_DROP, w);
    exp_drop = sat_inc(exp_drop);
    exp_ur   = sat_inc(exp_ur);
    check("ur_pulse",      ur_pulse, 1);
    check("ur_no_poison",  poison_pulse, 0);
    check("ur_cnt",        ur_cnt, exp_ur);
    idle(1);
    check("ur_pulse_1cy",  ur_pulse, 0);
    send_beat(mk_data(32'h3000_0000), '1, 1'b1, '0, R_DROP, w);
    exp_drop = sat_inc(exp_drop);
    check("msg_no_ur",     ur_pulse, 0);
    check("msg_ur_cnt",    ur_cnt, exp_ur);
    check("msg_drop_cnt",  drop_cnt, exp_drop);
    idle(2);

    // ---- 4-beat MWr under random req backpressure -------------------------
    bp_en = 1'b1;
    send_beat(mk_data(32'h4000_0010), '1, 1'b0, USR_BAR1, R_REQ, w);
    for (int i = 0; i < 3; i++)
      send_beat(mk_data($urandom), '1, 1'(i == 2), USR_BAR1, R_REQ, w);
    idle(2);
    bp_en = 1'b0;
    idle(3);
    check("bp_drained", req_q.size(), 0);

    // ---- Reset on beat 2 of a 4-beat MWr ---------------------------------
    send_beat(mk_data(32'h4000_0010), '1, 1'b0, USR_BAR1, R_REQ, w);
    send_beat(mk_data($urandom), '1, 1'b0, USR_BAR1, R_REQ, w);
    req_ready_force = 1'b0;          // leave beat 1 sitting in the stage
    s_if.tdata = mk_data($urandom); s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    user_reset = 1'b1;
    @(negedge user_clk);
    check("midrst_tready", s_if.tready, 0);
    @(posedge user_clk); #1;
    req_q.delete();                  // the stalled beat is abandoned
    exp_drop = '0;
    exp_ur   = '0;
    check("midrst_valids", {req_if.tvalid, cpl_if.tvalid}, 0);
    check("midrst_cnts",   {drop_cnt, ur_cnt}, 0);
    s_if.tvalid = 1'b0;
    user_reset = 1'b0;
    req_ready_force = 1'b1;
    idle(1);
    // A fresh 2-beat CplD must land on cpl, which needs the FSM back in SOF.
    send_beat(mk_data(32'h4A00_0001), '1, 1'b0, '0, R_CPL, w);
    send_beat(mk_data($urandom), 32'h0000_000F, 1'b1, '0, R_CPL, w);
    idle(3);
    check("post_rst_cpl", cpl_q.size(), 0);

    // ---- Counter saturation with 20 dropped messages ----------------------
    for (int i = 0; i < 20; i++) begin
      send_beat(mk_data(32'h3000_0000 | (i & 32'h7)), '1, 1'b1, '0, R_DROP, w);
      exp_drop = sat_inc(exp_drop);
    end
    idle(2);
    check("sat_drop_cnt", drop_cnt, STATS ? DATA_W'(4'hF) : DATA_W'(0));
    check("sat_model",    drop_cnt, exp_drop);
    check("sat_ur_cnt",   ur_cnt, exp_ur);

    idle(2);
    check("end_req_q", req_q.size(), 0);
    check("end_cpl_q", cpl_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
